// File: rtl/td4_sequencer.sv
// td4_sequencer: multi-cycle fetch/execute control unit for the TD4 4-bit
// A/B/C-register datapath. Owns pc, ir, carry flag and a retired counter.
module td4_sequencer #(
  parameter int CNT_W        = 16,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             run,
  input  logic             step,
  output logic             imem_req,
  output logic [3:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_rdata,
  input  logic             alu_carry,
  output logic             select_a,
  output logic             select_b,
  output logic             load0,
  output logic             load1,
  output logic             load2,
  output logic [3:0]       im,
  output logic             cf,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // Timer only needs to reach IMEM_TIMEOUT-1.
  localparam int TW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_STOP  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic             cf_q, cf_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] op;
  logic [1:0] dst, src;
  logic [3:0] pc_inc;

  assign op     = ir_q[7:4];
  assign dst    = op[3:2];
  assign src    = op[1:0];
  assign pc_inc = pc_q + 4'd1;

  // State and architectural registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= S_STOP;
      pc_q      <= 4'd0;
      ir_q      <= 8'h00;
      cf_q      <= 1'b0;
      timer_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cf_q      <= cf_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic plus the EXEC-cycle decode that drives the datapath.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cf_d      = cf_q;
    timer_d   = timer_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    select_a  = 1'b0;
    select_b  = 1'b0;
    load0     = 1'b0;
    load1     = 1'b0;
    load2     = 1'b0;

    case (state_q)
      S_STOP: begin
        if (run || step) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          timer_d = '0;
          state_d = S_EXEC;
        end else if (IMEM_TIMEOUT != 0) begin
          if (timer_q == TW'(IMEM_TIMEOUT - 1)) state_d = S_FAULT;
          else                                  timer_d = timer_q + TW'(1);
        end
      end

      S_EXEC: begin
        if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
        pc_d    = pc_inc;
        state_d = run ? S_FETCH : S_STOP;
        if (op < 4'd12) begin
          // MOV/ADD: destination in op[3:2], source in op[1:0].
          {select_b, select_a} = src;
          load0 = (dst == 2'd0);
          load1 = (dst == 2'd1);
          load2 = (dst == 2'd2);
          cf_d  = alu_carry;
        end else begin
          case (src)
            2'd1: begin              // HLT: pc and cf frozen
              pc_d    = pc_q;
              state_d = S_HALT;
            end
            2'd2: begin              // JNC on the carry from before this EXEC
              if (!cf_q) pc_d = ir_q[3:0];
              cf_d = 1'b0;
            end
            2'd3: begin              // JMP
              pc_d = ir_q[3:0];
              cf_d = 1'b0;
            end
            default: cf_d = 1'b0;    // NOP
          endcase
        end
      end

      S_HALT, S_FAULT: ;

      default: state_d = S_STOP;
    endcase
  end

  assign imem_addr = pc_q;
  assign im        = ir_q[3:0];
  assign cf        = cf_q;
  assign retired   = retired_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: bench with a program memory responder, a small A/B/C
// adder datapath and an instruction-level reference model.
module tb_td4_sequencer;
  localparam int CNT_W   = 4;
  localparam int TMO     = 4;
  localparam int RET_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, n_reset = 1'b0, run = 1'b0, step = 1'b0, imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic alu_carry;
  logic imem_req, select_a, select_b, load0, load1, load2, cf, busy, halted, fault;
  logic [3:0] imem_addr, im;
  logic [CNT_W-1:0] retired;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  td4_sequencer #(.CNT_W(CNT_W), .IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .alu_carry(alu_carry),
    .select_a(select_a), .select_b(select_b),
    .load0(load0), .load1(load1), .load2(load2), .im(im), .cf(cf),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  // Program memory: ack after lat_fixed wait cycles, or random 0..TMO-1 when negative.
  logic [7:0] mem [16];
  int lat_fixed = 0, wait_cnt = 0, cur_lat = 0;
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (imem_req) begin
      if (wait_cnt == 0) cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, TMO - 1));
      if (wait_cnt >= cur_lat) begin
        imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // Datapath: result = src + im, src {b,a}: 0=A 1=B 2=C 3=zero.
  logic [3:0] ra, rb, rc, dp_src;
  logic [4:0] dp_sum;
  always_comb begin
    case ({select_b, select_a})
      2'd0:    dp_src = ra;
      2'd1:    dp_src = rb;
      2'd2:    dp_src = rc;
      default: dp_src = 4'd0;
    endcase
    dp_sum = {1'b0, dp_src} + {1'b0, im};
  end
  assign alu_carry = dp_sum[4];
  always @(posedge clk) begin
    if (!n_reset) begin ra <= 4'd0; rb <= 4'd0; rc <= 4'd0; end
    else begin
      if (load0) ra <= dp_sum[3:0];
      if (load1) rb <= dp_sum[3:0];
      if (load2) rc <= dp_sum[3:0];
    end
  end

  // Instruction-level reference model.
  int m_pc, m_cf, m_ret, m_halt;
  int m_r [3];

  task automatic model_init();
    m_pc = 0; m_cf = 0; m_ret = 0; m_halt = 0;
    for (int i = 0; i < 3; i++) m_r[i] = 0;
  endtask

  task automatic model_exec(input int ins);
    int op, imm, d, s, v, sum;
    op = ins / 16; imm = ins % 16;
    if (m_ret < RET_MAX) m_ret++;
    if (op < 12) begin
      d = op / 4; s = op % 4;
      v = (s == 3) ? 0 : m_r[s];
      sum = v + imm;
      m_r[d] = sum % 16; m_cf = sum / 16; m_pc = (m_pc + 1) % 16;
    end else if (op == 12) begin m_pc = (m_pc + 1) % 16; m_cf = 0; end
    else if (op == 13) m_halt = 1;
    else if (op == 14) begin m_pc = (m_cf == 0) ? imm : (m_pc + 1) % 16; m_cf = 0; end
    else begin m_pc = imm; m_cf = 0; end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    run = 1'b0; step = 1'b0;
    @(negedge clk); n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); n_reset = 1'b1;
  endtask

  // One step pulse from STOP; counts FETCH/EXEC cycles and later requests.
  task automatic step_one(output int rq, output int ex, output int rq_after);
    int n;
    step = 1'b1; @(negedge clk); step = 1'b0;
    rq = 0; ex = 0; rq_after = 0; n = 0;
    while (busy === 1'b1 && n < 30) begin
      if (imem_req) rq++; else ex++;
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 30) begin errors++; $display("FAIL step_timeout cycles %0d limit 30", n); end
    repeat (4) begin @(negedge clk); if (imem_req) rq_after++; end
  endtask

  // Run a loaded program from reset, checking every cycle against the model.
  task automatic run_prog(input string tag, input int n_max);
    int n, cyc, ins, op;
    logic [2:0] exp_ld;
    n = 0; cyc = 0;
    model_init();
    run = 1'b1;
    while (m_halt == 0 && n < n_max && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (busy && !imem_req) begin
        ins = mem[m_pc]; op = ins / 16;
        exp_ld = (op < 12) ? 3'(1 << (op / 4)) : 3'd0;
        checks++;
        if ({load2, load1, load0} !== exp_ld || im !== 4'(ins % 16)) begin
          errors++;
          $display("FAIL %s exec_strobes ins %h got ld %b im %0d exp ld %b im %0d", tag, ins, {load2, load1, load0}, im, exp_ld, ins % 16);
        end
        if (op < 12) begin
          checks++;
          if ({select_b, select_a} !== 2'(op % 4)) begin
            errors++; $display("FAIL %s exec_select got %0d exp %0d", tag, {select_b, select_a}, op % 4);
          end
        end
        model_exec(ins); n++;
        if (n == n_max) run = 1'b0;
      end else begin
        checks++;
        if ({load2, load1, load0, select_b, select_a} !== 5'd0) begin
          errors++; $display("FAIL %s idle_strobes got %b exp 0", tag, {load2, load1, load0, select_b, select_a});
        end
        if (imem_req) begin
          checks++;
          if (imem_addr !== 4'(m_pc)) begin
            errors++; $display("FAIL %s fetch_addr got %0d exp %0d", tag, imem_addr, m_pc);
          end
        end
      end
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL %s cycle_budget got %0d instrs exp %0d", tag, n, n_max); end
    checks++;
    if (imem_addr !== 4'(m_pc) || cf !== 1'(m_cf) || retired !== CNT_W'(m_ret)) begin
      errors++;
      $display("FAIL %s final_state got pc %0d cf %0d ret %0d exp pc %0d cf %0d ret %0d", tag, imem_addr, cf, retired, m_pc, m_cf, m_ret);
    end
    checks++;
    if (ra !== 4'(m_r[0]) || rb !== 4'(m_r[1]) || rc !== 4'(m_r[2])) begin
      errors++;
      $display("FAIL %s final_regs got %0d %0d %0d exp %0d %0d %0d", tag, ra, rb, rc, m_r[0], m_r[1], m_r[2]);
    end
    checks++;
    if (halted !== 1'(m_halt) || busy !== 1'b0 || fault !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s final_status got h %b b %b f %b r %b exp h %0d b 0 f 0 r 0", tag, halted, busy, fault, imem_req, m_halt);
    end
  endtask

  task automatic test_reset();
    logic [21:0] all;
    run = 1'b0; step = 1'b0; n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    all = {imem_req, imem_addr, select_a, select_b, load0, load1, load2, im, cf, busy, halted, fault, retired};
    checks++;
    if (all !== 22'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all); end
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy %b req %b exp 0 0", busy, imem_req);
    end
  endtask

  task automatic test_mov_add_hlt();
    logic exp_l0, exp_req;
    fill_mem(8'hD0);
    mem[0] = 8'h33; mem[1] = 8'h01; mem[2] = 8'hD0;
    lat_fixed = 0;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_l0  = (c == 2 || c == 4);
      exp_req = (c == 1 || c == 3 || c == 5);
      checks++;
      if (load0 !== exp_l0 || imem_req !== exp_req || halted !== (c >= 7)) begin
        errors++;
        $display("FAIL mah_cycle%0d got l0 %b req %b h %b exp %b %b %b", c, load0, imem_req, halted, exp_l0, exp_req, c >= 7);
      end
      if (exp_l0) begin
        checks++;
        if ({select_b, select_a} !== ((c == 2) ? 2'd3 : 2'd0) || im !== ((c == 2) ? 4'd3 : 4'd1)) begin
          errors++; $display("FAIL mah_sel%0d got sel %0d im %0d", c, {select_b, select_a}, im);
        end
      end
    end
    run = 1'b0;
    checks++;
    if (retired !== CNT_W'(3) || imem_addr !== 4'd2 || ra !== 4'd4 || imem_req !== 1'b0) begin
      errors++; $display("FAIL mah_final got ret %0d pc %0d A %0d exp 3 2 4", retired, imem_addr, ra);
    end
  endtask

  task automatic test_jnc();
    int rq, ex, ra_;
    for (int k = 0; k < 2; k++) begin
      fill_mem(8'hD0);
      mem[0] = (k == 0) ? 8'h31 : 8'h30; mem[1] = 8'h0F; mem[2] = 8'hE7;
      lat_fixed = -1;
      do_reset();
      step_one(rq, ex, ra_);
      step_one(rq, ex, ra_);
      checks++;
      if (cf !== ((k == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL jnc%0d_cf_before got %b exp %0d", k, cf, k == 0);
      end
      step_one(rq, ex, ra_);
      checks++;
      if (imem_addr !== ((k == 0) ? 4'd3 : 4'd7) || cf !== 1'b0) begin
        errors++; $display("FAIL jnc%0d_target got pc %0d cf %b exp pc %0d cf 0", k, imem_addr, cf, (k == 0) ? 3 : 7);
      end
    end
  endtask

  task automatic test_step();
    int rq, ex, rq_after;
    fill_mem(8'hD0); mem[0] = 8'h35;
    lat_fixed = 2;
    do_reset();
    step_one(rq, ex, rq_after);
    checks++;
    if (rq != 3 || ex != 1 || rq_after != 0) begin
      errors++; $display("FAIL step_cycles got rq %0d ex %0d after %0d exp 3 1 0", rq, ex, rq_after);
    end
    checks++;
    if (busy !== 1'b0 || retired !== CNT_W'(1) || imem_addr !== 4'd1 || ra !== 4'd5) begin
      errors++; $display("FAIL step_state got busy %b ret %0d pc %0d A %0d exp 0 1 1 5", busy, retired, imem_addr, ra);
    end
  endtask

  task automatic test_timeout();
    int rq, n;
    fill_mem(8'hD0);
    lat_fixed = 1000;
    do_reset();
    run = 1'b1; rq = 0; n = 0;
    while (fault !== 1'b1 && n < 30) begin @(negedge clk); n++; if (imem_req) rq++; end
    checks++;
    if (rq != TMO || fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got rq %0d fault %b req %b exp %0d 1 0", rq, fault, imem_req, TMO);
    end
    run = 1'b0; step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_absorb got fault %b req %b exp 1 0", fault, imem_req);
    end
    lat_fixed = TMO - 1;
    do_reset();
    run = 1'b1; rq = 0; n = 0;
    while (halted !== 1'b1 && fault !== 1'b1 && n < 30) begin @(negedge clk); n++; if (imem_req) rq++; end
    run = 1'b0;
    checks++;
    if (rq != TMO || fault !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL timeout_late_ack got rq %0d fault %b halt %b exp %0d 0 1", rq, fault, halted, TMO);
    end
  endtask

  task automatic test_wrap();
    int rq, ex, ra_;
    fill_mem(8'hC0);
    mem[0] = 8'hFF; mem[14] = 8'hFD; mem[13] = 8'h3F;
    mem[15] = 8'hC0;
    // JMP 15 -> NOP wraps to 0 -> JMP 15 -> NOP, then carry setup at 13/14.
    lat_fixed = -1;
    do_reset();
    step_one(rq, ex, ra_);
    checks++;
    if (imem_addr !== 4'd15) begin errors++; $display("FAIL wrap_jmp got %0d exp 15", imem_addr); end
    step_one(rq, ex, ra_);
    checks++;
    if (imem_addr !== 4'd0 || cf !== 1'b0) begin
      errors++; $display("FAIL wrap_nop got pc %0d cf %b exp 0 0", imem_addr, cf);
    end
    // NOP must clear a set carry: reach 15 sequentially with cf=1.
    fill_mem(8'hC0);
    mem[0] = 8'hFD; mem[13] = 8'h3F; mem[14] = 8'h01; mem[15] = 8'hC0;
    do_reset();
    repeat (3) step_one(rq, ex, ra_);
    checks++;
    if (cf !== 1'b1 || ra !== 4'd0 || imem_addr !== 4'd15) begin
      errors++; $display("FAIL wrap_carry got cf %b A %0d pc %0d exp 1 0 15", cf, ra, imem_addr);
    end
    step_one(rq, ex, ra_);
    checks++;
    if (imem_addr !== 4'd0 || cf !== 1'b0 || retired !== CNT_W'(4)) begin
      errors++; $display("FAIL wrap_nop_cf got pc %0d cf %b ret %0d exp 0 0 4", imem_addr, cf, retired);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_mem(8'hD0); mem[0] = 8'h3F; mem[1] = 8'h01;
    lat_fixed = 3;
    do_reset();
    run = 1'b1; n = 0;
    while (!(retired === CNT_W'(2) && imem_req === 1'b1) && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (cf !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 4'd2) begin
      errors++; $display("FAIL rstmid_pre got cf %b req %b pc %0d exp 1 1 2", cf, imem_req, imem_addr);
    end
    n_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 4'd0 || retired !== '0 || cf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post got busy %b req %b pc %0d ret %0d cf %b exp 0 0 0 0 0", busy, imem_req, imem_addr, retired, cf);
    end
    run = 1'b0; n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int ins;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        ins = int'($urandom_range(0, 255));
        if (ins / 16 < 12 && (ins / 16) % 4 != 3 && (ins / 16) % 4 != ins / 64) ins = ins & 8'hF0;
        mem[i] = 8'(ins);
      end
      lat_fixed = -1;
      do_reset();
      run_prog($sformatf("rand%0d", p), 40);
    end
  endtask

  task automatic test_saturate();
    fill_mem(8'hC0);
    lat_fixed = -1;
    do_reset();
    run_prog("saturate", RET_MAX + 6);
    checks++;
    if (retired !== CNT_W'(RET_MAX)) begin
      errors++; $display("FAIL saturate_count got %0d exp %0d", retired, RET_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_mov_add_hlt();
    test_jnc();
    test_step();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
